// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and time-field widths for the stopwatch controller
package stopwatch_pkg;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;
  localparam int HUN_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_e;
endpackage

// File: rtl/rise_edge.sv
// rtl/rise_edge.sv - registered rising-edge detector; previous value resets high so a held button is silent
module rise_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise
);
  logic prev_q;
  logic prev_d;

  always_comb prev_d = din;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_q <= 1'b1;
    else          prev_q <= prev_d;
  end

  assign rise = din & ~prev_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control FSM: button events, hundredth tick divider, lap capture
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIV   = 500_000,
  parameter int LAP_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_stop,
  input  logic             lap,
  input  logic             clear,
  input  logic [MIN_W-1:0] live_mins,
  input  logic [SEC_W-1:0] live_secs,
  input  logic [HUN_W-1:0] live_hundredths,
  output logic             run,
  output logic             tick,
  output logic             clear_pulse,
  output logic             freeze,
  output logic [MIN_W-1:0] disp_mins,
  output logic [SEC_W-1:0] disp_secs,
  output logic [HUN_W-1:0] disp_hundredths,
  output logic [LAP_W-1:0] lap_cnt,
  output logic [1:0]       state
);
  localparam int              DIV_W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [LAP_W-1:0] LAP_MAX  = {LAP_W{1'b1}};

  sw_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;
  logic [MIN_W-1:0] lap_m_q, lap_m_d;
  logic [SEC_W-1:0] lap_s_q, lap_s_d;
  logic [HUN_W-1:0] lap_h_q, lap_h_d;
  logic             clear_pulse_q, clear_pulse_d;
  logic             ss_ev, lap_ev, clr_ev;

  rise_edge u_ss_edge  (.clk(clk), .reset_n(reset_n), .din(start_stop), .rise(ss_ev));
  rise_edge u_lap_edge (.clk(clk), .reset_n(reset_n), .din(lap),        .rise(lap_ev));
  rise_edge u_clr_edge (.clk(clk), .reset_n(reset_n), .din(clear),      .rise(clr_ev));

  assign run = (state_q == ST_RUN) || (state_q == ST_LAP);

  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    lap_cnt_d     = lap_cnt_q;
    lap_m_d       = lap_m_q;
    lap_s_d       = lap_s_q;
    lap_h_d       = lap_h_q;
    clear_pulse_d = 1'b0;

    if (run) div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

    // Only the highest-priority event of a cycle is considered, even if the state ignores it.
    if (clr_ev) begin
      if (state_q == ST_PAUSE) begin
        state_d       = ST_IDLE;
        clear_pulse_d = 1'b1;
        div_d         = '0;
        lap_cnt_d     = '0;
        lap_m_d       = '0;
        lap_s_d       = '0;
        lap_h_d       = '0;
      end
    end else if (ss_ev) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_LAP:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end else if (lap_ev && run) begin
      state_d   = ST_LAP;
      lap_m_d   = live_mins;
      lap_s_d   = live_secs;
      lap_h_d   = live_hundredths;
      lap_cnt_d = (lap_cnt_q == LAP_MAX) ? lap_cnt_q : lap_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      div_q         <= '0;
      lap_cnt_q     <= '0;
      lap_m_q       <= '0;
      lap_s_q       <= '0;
      lap_h_q       <= '0;
      clear_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      lap_cnt_q     <= lap_cnt_d;
      lap_m_q       <= lap_m_d;
      lap_s_q       <= lap_s_d;
      lap_h_q       <= lap_h_d;
      clear_pulse_q <= clear_pulse_d;
    end
  end

  assign tick            = run && (div_q == DIV_LAST);
  assign clear_pulse     = clear_pulse_q;
  assign freeze          = (state_q == ST_LAP);
  assign disp_mins       = freeze ? lap_m_q : live_mins;
  assign disp_secs       = freeze ? lap_s_q : live_secs;
  assign disp_hundredths = freeze ? lap_h_q : live_hundredths;
  assign lap_cnt         = lap_cnt_q;
  assign state           = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - table-driven and sequence checks of stopwatch_ctrl with DIV=4
module tb_stopwatch_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ss = 1'b0, lp = 1'b0, cl = 1'b0;
  logic [5:0] lm = '0, ls = '0;
  logic [6:0] lh = '0;
  logic       run, tick, clear_pulse, freeze;
  logic [5:0] dm, ds;
  logic [6:0] dh;
  logic [3:0] lap_cnt;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  stopwatch_ctrl #(.DIV(4), .LAP_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .start_stop(ss), .lap(lp), .clear(cl),
    .live_mins(lm), .live_secs(ls), .live_hundredths(lh),
    .run(run), .tick(tick), .clear_pulse(clear_pulse), .freeze(freeze),
    .disp_mins(dm), .disp_secs(ds), .disp_hundredths(dh),
    .lap_cnt(lap_cnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ss, lp, cl;
    logic [5:0] lm, ls;
    logic [6:0] lh;
    logic [1:0] st;
    logic [3:0] lc;
    logic [5:0] dm, ds;
    logic [6:0] dh;
    logic       cp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic hold_ss);
    ss = hold_ss; lp = 1'b0; cl = 1'b0;
    lm = '0; ls = '0; lh = '0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    //          ss lp cl  lm  ls  lh   st lc  dm  ds  dh  cp
    vecs[0]  = '{1, 0, 0,  0,  0,  0,   1, 0,  0,  0,  0, 0};
    vecs[1]  = '{0, 0, 0,  1, 23, 45,   1, 0,  1, 23, 45, 0};
    vecs[2]  = '{0, 1, 0,  1, 23, 45,   3, 1,  1, 23, 45, 0};
    vecs[3]  = '{0, 0, 0,  1, 23, 46,   3, 1,  1, 23, 45, 0};
    vecs[4]  = '{0, 0, 0,  1, 24,  0,   3, 1,  1, 23, 45, 0};
    vecs[5]  = '{0, 1, 0,  1, 24, 10,   3, 2,  1, 24, 10, 0};
    vecs[6]  = '{0, 0, 0,  2,  0,  0,   3, 2,  1, 24, 10, 0};
    vecs[7]  = '{1, 0, 0,  2,  0,  1,   2, 2,  2,  0,  1, 0};
    vecs[8]  = '{0, 1, 0,  2,  0,  1,   2, 2,  2,  0,  1, 0};
    vecs[9]  = '{1, 0, 1,  2,  0,  1,   0, 0,  2,  0,  1, 1};
    vecs[10] = '{0, 0, 0,  0,  0,  0,   0, 0,  0,  0,  0, 0};
    vecs[11] = '{0, 0, 1,  0,  0,  0,   0, 0,  0,  0,  0, 0};

    do_reset(1'b0);
    chk("reset_state", state, 0);
    chk("reset_run", run, 0);
    chk("reset_tick", tick, 0);
    chk("reset_freeze", freeze, 0);
    chk("reset_lap_cnt", lap_cnt, 0);
    chk("reset_clear_pulse", clear_pulse, 0);

    for (int i = 0; i < 12; i++) begin
      ss = vecs[i].ss; lp = vecs[i].lp; cl = vecs[i].cl;
      lm = vecs[i].lm; ls = vecs[i].ls; lh = vecs[i].lh;
      step();
      chk($sformatf("vec%0d_state", i), state, vecs[i].st);
      chk($sformatf("vec%0d_run", i), run, (vecs[i].st == 2'd1 || vecs[i].st == 2'd3) ? 1 : 0);
      chk($sformatf("vec%0d_freeze", i), freeze, (vecs[i].st == 2'd3) ? 1 : 0);
      chk($sformatf("vec%0d_lap_cnt", i), lap_cnt, vecs[i].lc);
      chk($sformatf("vec%0d_disp_mins", i), dm, vecs[i].dm);
      chk($sformatf("vec%0d_disp_secs", i), ds, vecs[i].ds);
      chk($sformatf("vec%0d_disp_hund", i), dh, vecs[i].dh);
      chk($sformatf("vec%0d_clear_pulse", i), clear_pulse, vecs[i].cp);
      chk($sformatf("vec%0d_tick_and_clear", i), tick & clear_pulse, 0);
    end

    // Tick cadence from IDLE, then fraction kept across a pause.
    do_reset(1'b0);
    ss = 1'b1;
    step();
    chk("start_state", state, 1);
    chk("start_tick0", tick, 0);
    ss = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      step();
      chk($sformatf("first_tick_c%0d", j), tick, (j == 3) ? 1 : 0);
    end
    ss = 1'b1;
    step();
    chk("pause_state", state, 2);
    chk("pause_run", run, 0);
    ss = 1'b0;
    for (int j = 0; j < 10; j++) begin
      step();
      chk($sformatf("paused_tick_c%0d", j), tick, 0);
    end
    ss = 1'b1;
    step();
    chk("resume_state", state, 1);
    chk("resume_tick_c0", tick, 0);
    ss = 1'b0;
    step();
    chk("resume_tick_c1", tick, 1);
    for (int k = 2; k <= 5; k++) begin
      step();
      chk($sformatf("resume_tick_c%0d", k), tick, (k == 5) ? 1 : 0);
    end

    // Lap counter saturation and clear ignored in RUN.
    do_reset(1'b0);
    ss = 1'b1; step(); ss = 1'b0; step();
    for (int n = 0; n < 16; n++) begin
      lp = 1'b1; step();
      lp = 1'b0; step();
    end
    chk("sat_lap_cnt", lap_cnt, 15);
    chk("sat_state", state, 3);
    ss = 1'b1; step(); ss = 1'b0; step();
    chk("sat_pause", state, 2);
    ss = 1'b1; step(); ss = 1'b0;
    chk("sat_resume", state, 1);
    cl = 1'b1; step();
    chk("run_clear_state", state, 1);
    chk("run_clear_pulse0", clear_pulse, 0);
    cl = 1'b0; step();
    chk("run_clear_pulse1", clear_pulse, 0);
    chk("run_clear_lap_cnt", lap_cnt, 15);

    // Reset mid-RUN aborts at once, no clear pulse.
    reset_n = 1'b0;
    #1;
    chk("async_reset_state", state, 0);
    chk("async_reset_run", run, 0);
    chk("async_reset_lap_cnt", lap_cnt, 0);
    chk("async_reset_clear_pulse", clear_pulse, 0);
    step();
    chk("async_reset_clear_pulse_next", clear_pulse, 0);

    // start_stop held through reset release produces no event.
    do_reset(1'b1);
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("held_ss_state_c%0d", j), state, 0);
    end
    ss = 1'b0;
    step();
    chk("held_ss_release_state", state, 0);
    chk("held_ss_release_run", run, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
